// File: rtl/dac_frame_serializer.sv
// dac_frame_serializer
//   Buffers signed 16-bit samples from the FIR stage in a small FIFO and
//   shifts each one out to an external DAC as a 24-bit SPI-style frame
//   ({CMD_BYTE, data}, MSB first). Samples arriving while the FIFO is full
//   are dropped and recorded in a sticky overflow flag.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   sample_in    signed sample, qualified by valid_in
//   valid_in     one-cycle sample strobe
//   overflow_clr synchronous clear of overflow (a drop in the same cycle wins)
//   dac_cs_n     frame select, active low
//   dac_sclk     serial clock, idle low, DAC samples on the rising edge
//   dac_sdo      serial data, MSB first
//   busy         high while a frame is shifting or in the inter-frame gap
//   frame_done   one-cycle pulse on the last gap cycle of each frame
//   fifo_level   number of occupied FIFO entries
//   overflow     sticky: a sample was dropped
module dac_frame_serializer #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned GAP_CYCLES    = 2,
    parameter logic [7:0]  CMD_BYTE      = 8'h30,
    parameter bit          OFFSET_BINARY = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   sample_in,
    input  logic                          valid_in,
    input  logic                          overflow_clr,
    output logic                          dac_cs_n,
    output logic                          dac_sclk,
    output logic                          dac_sdo,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    // ---------------------------------------------------------------
    // Sample FIFO
    // ---------------------------------------------------------------
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] count_q;
    logic [LW-1:0] count_d;
    logic          overflow_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push;
    logic          drop;
    logic [15:0]   head;
    logic [15:0]   data;
    logic [23:0]   frame_word;

    state_t        state_q;

    always_comb begin
        fifo_full  = (count_q == FULL_LVL);
        fifo_empty = (count_q == '0);
        // The IDLE pop frees a slot on the same edge, so a push into a
        // full FIFO is still accepted when it coincides with the pop.
        pop        = (state_q == IDLE) && !fifo_empty;
        push       = valid_in && (!fifo_full || pop);
        drop       = valid_in && fifo_full && !pop;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        head       = mem_q[rd_ptr_q];
        data       = OFFSET_BINARY ? {~head[15], head[14:0]} : head;
        frame_word = {CMD_BYTE, data};
    end

    // Storage carries no reset; occupancy is defined by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Frame shifter
    // ---------------------------------------------------------------
    logic [22:0]   rest_q;     // frame bits still to be shifted, next at [22]
    logic [DW-1:0] div_q;
    logic [4:0]    bit_cnt_q;  // rising sclk edges in the current frame
    logic [GW-1:0] gap_q;
    logic          cs_n_q;
    logic          sclk_q;
    logic          sdo_q;
    logic          busy_q;
    logic          frame_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rest_q       <= '0;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            gap_q        <= '0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            sdo_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        sdo_q     <= frame_word[23];
                        rest_q    <= frame_word[22:0];
                        cs_n_q    <= 1'b0;
                        div_q     <= '0;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (!sclk_q) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else if (bit_cnt_q == 5'd24) begin
                            // Falling edge after the 24th rise ends the frame.
                            cs_n_q  <= 1'b1;
                            sdo_q   <= 1'b0;
                            gap_q   <= '0;
                            state_q <= GAP;
                            // A one-cycle gap makes its first cycle the last.
                            frame_done_q <= (GAP_CYCLES == 1);
                        end else begin
                            sdo_q  <= rest_q[22];
                            rest_q <= {rest_q[21:0], 1'b0};
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                        // Registered pulse lands on the last gap cycle.
                        frame_done_q <= ((gap_q + 1'b1) == GAP_LAST);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_sdo    = sdo_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign fifo_level = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_dac_frame_serializer.sv
// tb_dac_frame_serializer
//   Directed bench for dac_frame_serializer. Three instances share clk and
//   reset: u_def (defaults), u_bin (OFFSET_BINARY=0) and u_fast (CLK_DIV=1,
//   GAP_CYCLES=1). A monitor reassembles every serial frame from dac_sdo on
//   rising dac_sclk and records word, bit count, cs_n low time and the
//   latency of the first sclk rise; directed scenarios compare those
//   records and the status outputs against hand-computed values.
module tb_dac_frame_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sin   [3];
    logic        valid [3];
    logic        oclr  [3];
    logic        cs_n  [3];
    logic        sclk  [3];
    logic        sdo   [3];
    logic        busy  [3];
    logic        fdone [3];
    logic        ovf   [3];
    logic [2:0]  lvl   [3];

    always #5 clk = ~clk;

    dac_frame_serializer u_def (
        .clk(clk), .reset(reset), .sample_in(sin[0]), .valid_in(valid[0]),
        .overflow_clr(oclr[0]), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]),
        .dac_sdo(sdo[0]), .busy(busy[0]), .frame_done(fdone[0]),
        .fifo_level(lvl[0]), .overflow(ovf[0])
    );

    dac_frame_serializer #(.OFFSET_BINARY(1'b0)) u_bin (
        .clk(clk), .reset(reset), .sample_in(sin[1]), .valid_in(valid[1]),
        .overflow_clr(oclr[1]), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]),
        .dac_sdo(sdo[1]), .busy(busy[1]), .frame_done(fdone[1]),
        .fifo_level(lvl[1]), .overflow(ovf[1])
    );

    dac_frame_serializer #(.CLK_DIV(1), .GAP_CYCLES(1)) u_fast (
        .clk(clk), .reset(reset), .sample_in(sin[2]), .valid_in(valid[2]),
        .overflow_clr(oclr[2]), .dac_cs_n(cs_n[2]), .dac_sclk(sclk[2]),
        .dac_sdo(sdo[2]), .busy(busy[2]), .frame_done(fdone[2]),
        .fifo_level(lvl[2]), .overflow(ovf[2])
    );

    // Directed vectors and hand-computed frames (MSB inverted when offset binary).
    localparam logic [15:0] OV_IN  [6] = '{16'h0A01, 16'h1B02, 16'h2C03, 16'h8D04, 16'hFE05, 16'h5F06};
    localparam logic [23:0] OV_FR  [5] = '{24'h308A01, 24'h309B02, 24'h30AC03, 24'h300D04, 24'h307E05};
    localparam int          OV_LVL [5] = '{1, 1, 2, 3, 4};
    localparam logic [15:0] A_IN   [6] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
    localparam logic [23:0] A_FR   [5] = '{24'h308101, 24'h308202, 24'h308303, 24'h308404, 24'h308505};
    localparam logic [15:0] F_IN   [4] = '{16'h0000, 16'h7FFF, 16'h5A5A, 16'hA5A5};
    localparam logic [23:0] F_FR   [4] = '{24'h308000, 24'h30FFFF, 24'h30DA5A, 24'h3025A5};

    // Monitor state
    int          frames  [3];
    int          fd_cnt  [3];
    int          max_lvl [3];
    int          nb      [3];
    int          lowc    [3];
    int          lat     [3];
    logic [23:0] sh      [3];
    logic        prev_s  [3];
    logic        prev_c  [3];
    logic [23:0] fw      [3][16];
    int          fbits   [3][16];
    int          flow    [3][16];
    int          flat    [3][16];
    int          nf      [3];

    int n_chk = 0;
    int n_pass = 0;

    initial begin
        for (int k = 0; k < 3; k++) begin
            frames[k] = 0; fd_cnt[k] = 0; max_lvl[k] = 0; nb[k] = 0;
            lowc[k] = 0; lat[k] = 0; sh[k] = '0; prev_s[k] = 1'b0; prev_c[k] = 1'b1;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (reset) begin
                    sh[k] = '0; nb[k] = 0; lowc[k] = 0; lat[k] = 0;
                    prev_s[k] = 1'b0; prev_c[k] = 1'b1;
                end else begin
                    if (fdone[k]) fd_cnt[k]++;
                    if (int'(lvl[k]) > max_lvl[k]) max_lvl[k] = int'(lvl[k]);
                    if (!cs_n[k]) begin
                        if (sclk[k] && !prev_s[k]) begin
                            if (nb[k] == 0) lat[k] = lowc[k];
                            sh[k] = {sh[k][22:0], sdo[k]};
                            nb[k]++;
                        end
                        lowc[k]++;
                    end else if (!prev_c[k]) begin
                        fw[k][frames[k][3:0]]    = sh[k];
                        fbits[k][frames[k][3:0]] = nb[k];
                        flow[k][frames[k][3:0]]  = lowc[k];
                        flat[k][frames[k][3:0]]  = lat[k];
                        frames[k]++;
                        sh[k] = '0; nb[k] = 0; lowc[k] = 0; lat[k] = 0;
                    end
                    prev_s[k] = sclk[k];
                    prev_c[k] = cs_n[k];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [15:0] v);
        valid[k] = 1'b1;
        sin[k]   = v;
        cyc();
        valid[k] = 1'b0;
    endtask

    task automatic check_frame(input int k, input logic [23:0] word, input int low, input int latency);
        int t;
        logic [3:0] idx;
        t = 0;
        while (frames[k] <= nf[k] && t < 2000) begin
            cyc();
            t++;
        end
        check($sformatf("u%0d_frame_seen", k), 32'(frames[k] > nf[k]), 1);
        if (frames[k] > nf[k]) begin
            idx = nf[k][3:0];
            check($sformatf("u%0d_frame_word", k), 32'(fw[k][idx]), 32'(word));
            check($sformatf("u%0d_frame_bits", k), fbits[k][idx], 24);
            check($sformatf("u%0d_cs_low_cycles", k), flow[k][idx], low);
            check($sformatf("u%0d_first_rise", k), flat[k][idx], latency);
            nf[k]++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0; oclr[k] = 1'b0; sin[k] = '0; nf[k] = 0;
        end

        // Reset values
        repeat (2) cyc();
        check("rst_cs_n", 32'(cs_n[0]), 1);
        check("rst_sclk", 32'(sclk[0]), 0);
        check("rst_sdo", 32'(sdo[0]), 0);
        check("rst_busy", 32'(busy[0]), 0);
        check("rst_frame_done", 32'(fdone[0]), 0);
        check("rst_level", 32'(lvl[0]), 0);
        check("rst_overflow", 32'(ovf[0]), 0);
        reset = 1'b0;
        repeat (2) cyc();

        // Single sample, defaults: latency and full frame
        send(0, 16'h1234);
        check("lat_level_n1", 32'(lvl[0]), 1);
        check("lat_cs_n_n1", 32'(cs_n[0]), 1);
        cyc();
        check("lat_cs_n_n2", 32'(cs_n[0]), 0);
        check("lat_level_n2", 32'(lvl[0]), 0);
        check("lat_busy_n2", 32'(busy[0]), 1);
        check("lat_sdo_bit23", 32'(sdo[0]), 0);
        check_frame(0, 24'h309234, 192, 4);
        check("gap_busy", 32'(busy[0]), 1);
        repeat (4) cyc();
        check("idle_busy", 32'(busy[0]), 0);
        check("frame_done_once", fd_cnt[0], 1);

        // Code conversion
        send(0, 16'hFFFF);
        check_frame(0, 24'h307FFF, 192, 4);
        repeat (4) cyc();
        send(0, 16'h8000);
        check_frame(0, 24'h300000, 192, 4);
        send(1, 16'hFFFF);
        check_frame(1, 24'h30FFFF, 192, 4);
        repeat (4) cyc();

        // Overflow: six back-to-back valids into an idle block
        valid[0] = 1'b1;
        sin[0]   = OV_IN[0];
        for (int i = 1; i < 6; i++) begin
            cyc();
            check("ovf_level", 32'(lvl[0]), OV_LVL[i-1]);
            check("ovf_not_yet", 32'(ovf[0]), 0);
            sin[0] = OV_IN[i];
        end
        cyc();
        valid[0] = 1'b0;
        check("ovf_level_peak", 32'(lvl[0]), 4);
        check("ovf_set", 32'(ovf[0]), 1);
        for (int i = 0; i < 5; i++) check_frame(0, OV_FR[i], 192, 4);
        repeat (300) cyc();
        check("ovf_no_extra_frame", frames[0], nf[0]);
        check("ovf_sticky", 32'(ovf[0]), 1);
        check("ovf_drained_level", 32'(lvl[0]), 0);
        oclr[0] = 1'b1;
        cyc();
        oclr[0] = 1'b0;
        check("ovf_cleared", 32'(ovf[0]), 0);
        check("frame_done_per_frame", fd_cnt[0], frames[0]);

        // Simultaneous events: clear vs drop, push while full at the IDLE pop
        valid[0] = 1'b1;
        sin[0]   = A_IN[0];
        for (int i = 1; i < 6; i++) begin
            cyc();
            sin[0] = A_IN[i];
            if (i == 5) oclr[0] = 1'b1;
        end
        cyc();
        valid[0] = 1'b0;
        oclr[0]  = 1'b0;
        check("clr_drop_level", 32'(lvl[0]), 4);
        check("clr_vs_drop", 32'(ovf[0]), 1);
        oclr[0] = 1'b1;
        cyc();
        oclr[0] = 1'b0;
        check("clr_alone", 32'(ovf[0]), 0);
        check_frame(0, A_FR[0], 192, 4);
        t = 0;
        while (!fdone[0] && t < 400) begin
            cyc();
            t++;
        end
        check("frame_done_seen", 32'(fdone[0]), 1);
        cyc();
        check("idle_full_level", 32'(lvl[0]), 4);
        check("idle_full_busy", 32'(busy[0]), 0);
        valid[0] = 1'b1;
        sin[0]   = 16'hC0DE;
        cyc();
        valid[0] = 1'b0;
        check("pushpop_level", 32'(lvl[0]), 4);
        check("pushpop_no_drop", 32'(ovf[0]), 0);
        check("pushpop_busy", 32'(busy[0]), 1);
        for (int i = 1; i < 5; i++) check_frame(0, A_FR[i], 192, 4);
        check_frame(0, 24'h3040DE, 192, 4);
        repeat (4) cyc();

        // Reset mid-frame
        valid[0] = 1'b1;
        sin[0]   = 16'h1111;
        cyc();
        sin[0] = 16'h2222;
        cyc();
        sin[0] = 16'h3333;
        cyc();
        valid[0] = 1'b0;
        check("pre_reset_level", 32'(lvl[0]), 2);
        t = 0;
        while (nb[0] < 10 && t < 1000) begin
            cyc();
            t++;
        end
        check("bit10_reached", nb[0], 10);
        reset = 1'b1;
        #1;
        check("midrst_cs_n", 32'(cs_n[0]), 1);
        check("midrst_sclk", 32'(sclk[0]), 0);
        check("midrst_sdo", 32'(sdo[0]), 0);
        check("midrst_level", 32'(lvl[0]), 0);
        check("midrst_busy", 32'(busy[0]), 0);
        cyc();
        cyc();
        reset = 1'b0;
        repeat (300) cyc();
        check("midrst_no_resume_frames", frames[0], nf[0]);
        check("midrst_no_resume_low", lowc[0], 0);
        check("midrst_cs_idle", 32'(cs_n[0]), 1);
        send(0, 16'h4321);
        check_frame(0, 24'h30C321, 192, 4);
        repeat (4) cyc();
        check("midrst_frame_done_count", fd_cnt[0], frames[0]);

        // CLK_DIV=1, GAP_CYCLES=1: one sample every 50 cycles
        for (int i = 0; i < 4; i++) begin
            send(2, F_IN[i]);
            repeat (49) cyc();
        end
        for (int i = 0; i < 4; i++) check_frame(2, F_FR[i], 48, 1);
        repeat (3) cyc();
        check("fast_max_level_le1", 32'(max_lvl[2] <= 1), 1);
        check("fast_no_overflow", 32'(ovf[2]), 0);
        check("fast_frame_done_count", fd_cnt[2], 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dac_frame_serializer.md
# dac_frame_serializer

Downstream consumer of the 4-channel FIR stage's conduit output. It takes filtered signed 16-bit samples on a valid-strobe interface and buffers them in a small FIFO. Each sample is converted to the DAC's code format and shifted out as a 24-bit SPI-style frame (8-bit command plus 16-bit data) to an external DAC. It decouples the FIR's bursty `valid_out` from the fixed-rate serial link and flags dropped samples.

## Interface
- `FIFO_DEPTH`, 4: sample FIFO depth. Power of two, 2..16.
- `CLK_DIV`, 4: half-period of `dac_sclk` in `clk` cycles. Must be ≥1.
- `GAP_CYCLES`, 2: `dac_cs_n` high time between frames, in `clk` cycles. Must be ≥1.
- `CMD_BYTE`, 8'h30: command byte sent in frame bits 23..16.
- `OFFSET_BINARY`, 1: 1 = invert the sample MSB (two's complement → offset binary); 0 = pass the sample unchanged.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_in`  in  16  signed sample from the FIR wrapper `sample_out`.
- `valid_in`  in  1  one-cycle qualifier for `sample_in`.
- `overflow_clr`  in  1  synchronous clear of `overflow`.
- `dac_cs_n`  out  1  frame select, active low.
- `dac_sclk`  out  1  serial clock, idle low. The DAC samples on the rising edge.
- `dac_sdo`  out  1  serial data, MSB first.
- `busy`  out  1  high while in SHIFT or GAP.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current number of occupied FIFO entries.
- `overflow`  out  1  sticky flag: a sample was dropped.

## Operation
- **Reset values** (applied asynchronously):
  - `dac_cs_n`=1, `dac_sclk`=0, `dac_sdo`=0.
  - `busy`=0, `frame_done`=0, `overflow`=0.
  - FIFO emptied, `fifo_level`=0, state = IDLE.
- **Push:**
  - A push occurs when `valid_in`=1 and either the FIFO is not full or a pop happens in the same cycle.
  - If `valid_in`=1 while the FIFO is full and no pop occurs, the sample is dropped and `overflow` is set to 1.
  - `overflow` clears only on `reset`, or on `overflow_clr` when no drop occurs in that cycle. A simultaneous drop wins.
- **Code conversion** (applied at pop): data = `OFFSET_BINARY` ? {~s[15], s[14:0]} : s. The frame word is {`CMD_BYTE`, data}.
- **IDLE:**
  - If the FIFO is not empty, pop on this edge.
  - Load the 24-bit shift register with the frame word.
  - Drive `dac_sdo` = bit 23 and `dac_cs_n` = 0.
  - Clear the divider and bit counters, then go to SHIFT.
- **SHIFT:**
  - The divider counts 0..`CLK_DIV`-1.
  - At each terminal count, `dac_sclk` toggles.
  - On each low→high toggle, the bit counter increments.
  - On each high→low toggle that is not the last, `dac_sdo` takes the next lower bit.
  - After the 24th falling toggle: `dac_cs_n`=1, `dac_sdo`=0, go to GAP.
- **GAP:**
  - Hold for `GAP_CYCLES` cycles.
  - `frame_done` pulses on the last GAP cycle, then the state returns to IDLE.
- **Reset mid-frame:** the frame is abandoned. Outputs return to reset values immediately; no partial frame resumes.
- **Sample count:** a sample is never duplicated; every popped sample produces exactly one complete frame.

## Timing
- **Input to frame latency** (empty FIFO, IDLE): `valid_in` is high in cycle N. `fifo_level`=1 in cycle N+1. The pop edge ends cycle N+1, so `dac_cs_n`=0 from cycle N+2.
- **Frame length:** `dac_cs_n` is low for exactly 48·`CLK_DIV` cycles. The first `dac_sclk` rise is `CLK_DIV` cycles after `dac_cs_n` falls.
- **`dac_sdo` setup and hold:** stable for ≥`CLK_DIV` cycles before and after each rising `dac_sclk`.
- **Frame period:** minimum 48·`CLK_DIV` + `GAP_CYCLES` + 1 cycles (one IDLE cycle).
  - Defaults: 195 cycles.
  - The upstream sample rate must not exceed `clk`/195, or `overflow` will set.
- **`fifo_level` updates:** one cycle after the push or pop edge.
- **Push and pop in the same cycle:** `fifo_level` is unchanged.
- **`frame_done`:** high for exactly 1 cycle per frame.
- **`busy`:** high from the pop edge through the last GAP cycle.

## Test plan
- **Single sample, defaults:** `sample_in`=16'h1234 → one frame shifting 24'h309234 MSB first. `dac_cs_n` is low for 192 cycles and there are 24 `dac_sclk` rises; `frame_done` pulses once.
- **Code conversion:**
  - With `OFFSET_BINARY`=1: -1 (16'hFFFF) → data 16'h7FFF; 16'h8000 → 16'h0000.
  - With `OFFSET_BINARY`=0: 16'hFFFF is sent as 16'hFFFF.
- **Overflow:** 6 back-to-back valids (s0..s5) into an idle block, `FIFO_DEPTH`=4.
  - s0 pops at the second edge and the level peaks at 4.
  - s5 is dropped and `overflow`=1.
  - Five frames s0..s4 are sent in order, and `overflow` stays 1 until `overflow_clr`.
- **Simultaneous events:** `overflow_clr` and a drop in the same cycle → `overflow` stays 1. A push while full that coincides with the IDLE pop → accepted, `fifo_level` unchanged.
- **Reset mid-frame:** assert `reset` during bit 10 → `dac_cs_n`=1, `dac_sclk`=0 and `fifo_level`=0 immediately. After release, the first new `valid_in` produces a clean full frame.
- **`CLK_DIV`=1, `GAP_CYCLES`=1:** a continuous sample every 50 cycles → `dac_sclk` toggles every cycle. Frames are 48 cycles long, no `overflow`, and `fifo_level` ≤1.
